// File: rtl/cic_decimator_if.sv
// Sample/result bus of the CIC decimator: bitstream in, decimated words out.
interface cic_decimator_if #(
    parameter int NUMBITS = 25,
    parameter int SEL_W   = 4
);
    logic               in;
    logic               in_valid;
    logic [SEL_W-1:0]   dec_log2;
    logic [NUMBITS-1:0] out;
    logic               out_valid;
    logic [SEL_W-1:0]   dec_active;

    modport master (output in, in_valid, dec_log2, input out, out_valid, dec_active);
    modport slave  (input in, in_valid, dec_log2, output out, out_valid, dec_active);
endinterface

// File: rtl/cic_decimator.sv
// Nth-order CIC decimator for a 1-bit sigma-delta stream, run-time ratio 2**dec_log2.
// Optional CIC_BIPOLAR_EN: code in=0 as -1 instead of 0.
module cic_decimator #(
    parameter int ORDER        = 3,
    parameter int MAX_DEC_LOG2 = 8,
    parameter int MIN_DEC_LOG2 = 2,
    parameter int NUMBITS      = ORDER*MAX_DEC_LOG2+1,
    parameter int SEL_W        = $clog2(MAX_DEC_LOG2+1)
) (
    input logic             clk,
    input logic             reset,
    cic_decimator_if.slave  bus
);
    localparam int STAGES = 1;
    localparam int WCNT_W = $clog2(ORDER+1);
    localparam logic [MAX_DEC_LOG2-1:0] FRAME_ONES = '1;

    typedef enum logic {WARMUP, RUN} state_t;

    state_t                  state;
    logic [MAX_DEC_LOG2-1:0] frame_cnt;
    logic [MAX_DEC_LOG2-1:0] frame_last;
    logic [WCNT_W-1:0]       warm_cnt;
    logic [SEL_W-1:0]        dec_act;
    logic [SEL_W-1:0]        dec_req;
    logic [STAGES:0]         vld_pipe;
    logic                    eval_q;
    logic                    tick;
    logic                    chg;
    logic [NUMBITS-1:0]      x;
    logic [NUMBITS-1:0]      out_r;
    logic [NUMBITS-1:0]      comb_out;

    function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] v);
        if (v < SEL_W'(MIN_DEC_LOG2)) return SEL_W'(MIN_DEC_LOG2);
        if (v > SEL_W'(MAX_DEC_LOG2)) return SEL_W'(MAX_DEC_LOG2);
        return v;
    endfunction

    assign dec_req    = clamp_sel(bus.dec_log2);
    assign frame_last = FRAME_ONES >> (SEL_W'(MAX_DEC_LOG2) - dec_act);
    assign tick       = bus.in_valid && (frame_cnt == frame_last);
    assign chg        = tick && (dec_req != dec_act);

`ifdef CIC_BIPOLAR_EN
    assign x = bus.in ? NUMBITS'(1) : '1;
`else
    assign x = bus.in ? NUMBITS'(1) : '0;
`endif

    // Integrators chain combinationally so every stage includes the current sample.
    for (genvar k = 0; k < ORDER; k++) begin : g_int
        logic [NUMBITS-1:0] acc;
        logic [NUMBITS-1:0] nxt;
        if (k == 0) begin : g_first
            assign nxt = acc + x;
        end else begin : g_next
            assign nxt = acc + g_int[k-1].nxt;
        end
        always_ff @(posedge clk) begin
            if (reset)             acc <= '0;
            else if (bus.in_valid) acc <= nxt;
        end
    end

    // Combs are evaluated the cycle after a tick, once the integrators hold sample D-1.
    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        logic [NUMBITS-1:0] din;
        logic [NUMBITS-1:0] z;
        logic [NUMBITS-1:0] dout;
        if (k == 0) begin : g_first
            assign din = g_int[ORDER-1].acc;
        end else begin : g_next
            assign din = g_comb[k-1].dout;
        end
        assign dout = din - z;
        always_ff @(posedge clk) begin
            if (reset || chg) z <= '0;
            else if (eval_q)  z <= din;
        end
    end

    assign comb_out = g_comb[ORDER-1].dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WARMUP;
            warm_cnt  <= '0;
            frame_cnt <= '0;
            dec_act   <= dec_req;
            vld_pipe  <= '0;
            eval_q    <= 1'b0;
            out_r     <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            vld_pipe[0]        <= tick && !chg && (state == RUN);
            eval_q             <= tick && !chg;
            if (vld_pipe[0]) out_r <= comb_out;
            if (bus.in_valid) frame_cnt <= tick ? '0 : frame_cnt + 1'b1;
            // A ratio change drops this tick's result and restarts warm-up.
            if (chg) begin
                dec_act  <= dec_req;
                state    <= WARMUP;
                warm_cnt <= '0;
            end else if (tick && state == WARMUP) begin
                warm_cnt <= warm_cnt + 1'b1;
                if (warm_cnt == WCNT_W'(ORDER-1)) state <= RUN;
            end
        end
    end

    assign bus.out        = out_r;
    assign bus.out_valid  = vld_pipe[STAGES];
    assign bus.dec_active = dec_act;
endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator (ORDER=3, D=4..256), strobe timing and values.
module tb_cic_decimator;
    localparam int W = 25;
`ifdef CIC_BIPOLAR_EN
    localparam logic [63:0] ALT_VAL  = 64'd0;
    localparam logic [63:0] ZERO_VAL = 64'h1FFFFC0;
`else
    localparam logic [63:0] ALT_VAL  = 64'd32;
    localparam logic [63:0] ZERO_VAL = 64'd0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    cic_decimator_if #(.NUMBITS(W), .SEL_W(4)) bus();

    cic_decimator #(.ORDER(3), .MAX_DEC_LOG2(8), .MIN_DEC_LOG2(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int base = 0;
    int st_cyc[$];
    logic [W-1:0] st_val[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (bus.out_valid) begin
            st_cyc.push_back(cyc - base);
            st_val.push_back(bus.out);
        end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, expv, expv);
        end
    endtask

    task automatic apply_reset(input logic [3:0] d, input int n);
        reset = 1'b1;
        bus.dec_log2 = d;
        bus.in = 1'b0;
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic release_rst();
        reset = 1'b0;
        base = cyc;
        st_cyc.delete();
        st_val.delete();
    endtask

    // vmode 0: in_valid always 1, 1: valid on even steps. imode 0/1: constant, 2: 1,0,1,0
    task automatic run(input int n, input int vmode, input int imode);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = (vmode == 0) ? 1'b1 : (i % 2 == 0);
            bus.in = (imode == 2) ? (i % 2 == 0) : (imode == 1);
            @(negedge clk);
        end
    endtask

    task automatic check_strobes(input string tag, input int exp_n, input int first,
                                 input int period, input logic [63:0] val);
        check({tag, ".count"}, st_cyc.size(), exp_n);
        for (int k = 0; k < st_cyc.size() && k < exp_n; k++) begin
            check($sformatf("%s.cyc%0d", tag, k), st_cyc[k], first + k*period);
            check($sformatf("%s.val%0d", tag, k), st_val[k], val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in = 1'b0;
        bus.in_valid = 1'b0;
        bus.dec_log2 = 4'd2;
        @(negedge clk);

        // reset state and ratio clamping
        apply_reset(4'd15, 2);
        check("t1.clamp_hi", bus.dec_active, 8);
        apply_reset(4'd1, 2);
        check("t1.clamp_lo", bus.dec_active, 2);
        apply_reset(4'd2, 3);
        check("t1.out", bus.out, 0);
        check("t1.out_valid", bus.out_valid, 0);
        check("t1.dec_active", bus.dec_active, 2);

        // D=4 constant ones: ticks at 4,8,12 suppressed, strobes at 17,21,25
        release_rst();
        run(28, 0, 1);
        check_strobes("t2", 3, 17, 4, 64);
        check("t2.hold_out", bus.out, 64);
        check("t2.hold_vld", bus.out_valid, 0);

        apply_reset(4'd2, 2);
        release_rst();
        run(20, 0, 2);
        check_strobes("alt", 1, 17, 4, ALT_VAL);

        apply_reset(4'd2, 2);
        release_rst();
        run(20, 0, 0);
        check_strobes("zero", 1, 17, 4, ZERO_VAL);

        // in_valid every other cycle doubles the strobe period
        apply_reset(4'd2, 2);
        release_rst();
        run(50, 1, 1);
        check_strobes("t4", 3, 32, 8, 64);

        // D=256: full 25-bit result 2**24
        apply_reset(4'd8, 2);
        release_rst();
        check("t3.dec_active", bus.dec_active, 8);
        run(1290, 0, 1);
        check_strobes("t3", 2, 1025, 256, 64'd16777216);

        // ratio change mid-frame takes effect at the next tick (P20), result dropped
        apply_reset(4'd2, 2);
        release_rst();
        run(18, 0, 1);
        bus.dec_log2 = 4'd3;
        run(1, 0, 1);
        check("t5.active_hold", bus.dec_active, 2);
        run(1, 0, 1);
        check("t5.active_new", bus.dec_active, 3);
        run(43, 0, 1);
        check("t5.count", st_cyc.size(), 3);
        check("t5.cyc0", st_cyc.size() > 0 ? st_cyc[0] : -1, 17);
        check("t5.val0", st_cyc.size() > 0 ? st_val[0] : '0, 64);
        check("t5.cyc1", st_cyc.size() > 1 ? st_cyc[1] : -1, 53);
        check("t5.val1", st_cyc.size() > 1 ? st_val[1] : '0, 512);
        check("t5.cyc2", st_cyc.size() > 2 ? st_cyc[2] : -1, 61);
        check("t5.val2", st_cyc.size() > 2 ? st_val[2] : '0, 512);

        // reset the cycle after a tick kills the pending strobe
        apply_reset(4'd2, 2);
        release_rst();
        run(20, 0, 1);
        reset = 1'b1;
        @(negedge clk);
        check("t6.vld_after_rst", bus.out_valid, 0);
        check("t6.out_after_rst", bus.out, 0);
        repeat (3) @(negedge clk);
        check("t6.count", st_cyc.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
